buf_arb_mon: RTL
================

# buf_arb_mon

Parametrised transmit-side buffer arbiter and monitor for the PHY TX path. It sits between NQ egress FIFOs (request, memory, network, …) and the TX datapath mux. Each cycle it selects one non-empty queue by fixed priority, with anti-starvation forcing and a request-lock override. It also generates hysteretic TX back-pressure from one monitored queue's free space, and a stretched post-reset FIFO reset pulse.

## Interface
Parameters:
- NQ, 3, number of queues (2..8); index 0 is highest priority.
- SPACE_W, 4, width of each queue's free-space count.
- PAUSE_Q, 2, index of the queue whose space drives tx_pause.
- PAUSE_ON, 5, tx_pause sets when that space < PAUSE_ON.
- PAUSE_OFF, 8, tx_pause clears when that space >= PAUSE_OFF; must be >= PAUSE_ON.
- STARVE_MAX, 15, cycles a non-empty queue may be bypassed before a forced grant; must be >= 1.
- RST_HOLD, 4, cycles q_reset stays high after reset deasserts.
- SEL_W, $clog2(NQ), width of sel.

Ports:
- clk, in, 1: single clock.
- reset, in, 1: asynchronous, active-high.
- q_empty, in, NQ: per-queue empty flag.
- q_space, in, NQ*SPACE_W: free-space counts; queue i is bits [i*SPACE_W +: SPACE_W].
- lock, in, 1: request-in-progress. While high, only queue 0 may be granted.
- q_read, out, NQ: one-hot read strobe, or all zero.
- sel, out, SEL_W: index of the granted queue; 0 when idle.
- sel_valid, out, 1: a queue is granted this cycle. Low means the TX path sends idle.
- q_reset, out, NQ: FIFO reset, identical on all bits.
- tx_pause, out, 1: de-asserts upstream tready.

## Operation
- Reset state:
  - q_reset = all ones, tx_pause = 1.
  - Starvation counters = 0, hold counter = 0.
  - q_read = 0, sel = 0, sel_valid = 0.
- Reset hold:
  - After reset deasserts, q_reset stays high for exactly RST_HOLD clk edges, then drops and stays low until the next reset.
  - While q_reset is high: no grants, counters are held at 0, tx_pause is held at 1.
- Arbitration is combinational from current inputs plus registered counters, evaluated in this order:
  1. lock high: grant queue 0 if !q_empty[0]; otherwise idle. Other queues are blocked.
  2. Any starving queue (counter == STARVE_MAX and non-empty): grant the lowest-index starving queue.
  3. Otherwise grant the lowest-index non-empty queue.
  4. All empty: idle (sel_valid = 0, sel = 0, q_read = 0).
- A read strobe is never issued to an empty queue.
- q_read[sel] = sel_valid.
- Starvation counter i, updated at each edge while q_reset is low:
  - Cleared to 0 if queue i is granted or q_empty[i] is high.
  - Otherwise incremented, saturating at STARVE_MAX.
  - Counters keep incrementing while lock holds other queues off, so a starving queue wins on the first cycle after lock falls.
- tx_pause is a registered state with hysteresis on s = q_space[PAUSE_Q]:
  - Next value is 1 if s < PAUSE_ON.
  - Next value is 0 if s >= PAUSE_OFF.
  - Otherwise it holds.
  - The comparison is unsigned at SPACE_W bits.

## Timing
- q_read, sel and sel_valid have zero latency: they respond to q_empty and lock in the same cycle. The consuming FIFO pops on the clk edge where q_read is high.
- A starvation counter reaching STARVE_MAX at edge k forces the grant during cycle k (i.e. after edge k).
- A queue that is non-empty but never granted is therefore granted within at most STARVE_MAX+1 cycles. If several queues are starving, each waits at most an additional NQ cycles.
- tx_pause changes 1 cycle after the space crossing.
- Reset asserted mid-operation:
  - All outputs take their reset values immediately (asynchronously).
  - An in-flight read strobe is dropped.
- Simultaneous lock rise and starvation of another queue: lock wins, and the starving queue's counter stays saturated.
- q_empty[i] rising on the same cycle its counter saturates: no grant, and the counter clears.

## Test plan
- **Reset hold:** pulse reset with RST_HOLD=4 and all queues non-empty -> q_reset and tx_pause stay 1 for 4 edges after release, with no q_read. On the 5th cycle sel=0, q_read=3'b001.
- **Priority:** q_empty=3'b000 with lock low -> sel=0. Set q_empty=3'b001 -> sel=1. Set q_empty=3'b011 -> sel=2. Set q_empty=3'b111 -> sel_valid=0, q_read=0.
- **Starvation:** NQ=3, STARVE_MAX=15, queues 0 and 2 held non-empty -> queue 2 is granted exactly once every 16 cycles, and queue 0 in all other cycles.
- **Lock:** lock=1 with q_empty=3'b001 -> idle. Queue 1 waits 20 cycles. Drop lock -> sel=1 on that same cycle.
- **Pause hysteresis:** sweep q_space[PAUSE_Q] through 9,5,4,6,7,8 -> tx_pause reads 0,0,1,1,1,0, each value appearing one cycle after the corresponding input.
- **Mid-operation reset:** assert reset while sel=2 -> q_read=0 and q_reset=all ones immediately. After release, starvation counters are 0, so queue 2 is not force-granted early.

Source files
------------

// File: rtl/buf_arb_mon.sv
// ---------------------------------------------------------------------------
// buf_arb_mon
//
// Transmit-side buffer arbiter and monitor for the PHY TX path.
//
// Each cycle one non-empty egress queue is picked for the TX datapath mux:
//   - while lock is high, only queue 0 may be granted
//   - otherwise the lowest-index starving queue wins, if there is one
//   - otherwise the lowest-index non-empty queue wins
// Alongside the arbiter, the block generates a hysteretic back-pressure flag
// from one queue's free space. It also stretches reset into a FIFO reset
// pulse that lasts RST_HOLD clock edges after reset is released.
//
// Ports:
//   clk       in   1               single clock
//   reset     in   1               asynchronous, active-high
//   q_empty   in   NQ              per-queue empty flag
//   q_space   in   NQ*SPACE_W      free-space counts, queue i at [i*SPACE_W +: SPACE_W]
//   lock      in   1               request in progress: only queue 0 may be granted
//   q_read    out  NQ              one-hot read strobe (or zero)
//   sel       out  SEL_W           granted queue index, 0 when idle
//   sel_valid out  1               a queue is granted this cycle
//   q_reset   out  NQ              FIFO reset, identical on all bits
//   tx_pause  out  1               de-asserts upstream tready
// ---------------------------------------------------------------------------
module buf_arb_mon #(
  parameter int NQ         = 3,
  parameter int SPACE_W    = 4,
  parameter int PAUSE_Q    = 2,
  parameter int PAUSE_ON   = 5,
  parameter int PAUSE_OFF  = 8,
  parameter int STARVE_MAX = 15,
  parameter int RST_HOLD   = 4,
  parameter int SEL_W      = $clog2(NQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NQ-1:0]         q_empty,
  input  logic [NQ*SPACE_W-1:0] q_space,
  input  logic                  lock,
  output logic [NQ-1:0]         q_read,
  output logic [SEL_W-1:0]      sel,
  output logic                  sel_valid,
  output logic [NQ-1:0]         q_reset,
  output logic                  tx_pause
);

  localparam int CNT_W  = $clog2(STARVE_MAX + 1);
  localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(STARVE_MAX);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((RST_HOLD > 1) ? RST_HOLD - 1 : 0);
  localparam logic [SPACE_W:0]  ON_THR    = (SPACE_W + 1)'(PAUSE_ON);
  localparam logic [SPACE_W:0]  OFF_THR   = (SPACE_W + 1)'(PAUSE_OFF);

  typedef enum logic {
    ST_HOLD,
    ST_RUN
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [HOLD_W-1:0]  hold_cnt;
  logic               hold_active;
  logic [CNT_W-1:0]   starve_cnt [NQ];
  logic [NQ-1:0]      starving;
  logic               grant_valid;
  logic [SEL_W-1:0]   grant_idx;
  logic               found;
  logic [SPACE_W-1:0] mon_space;
  logic               unused_space;

  // Post-reset hold state register. The FIFOs stay in reset while ST_HOLD
  // is active, and only the hold timer can move the block to ST_RUN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_HOLD;
    end else begin
      state_q <= state_d;
    end
  end

  // Leave ST_HOLD on the RST_HOLD-th edge after reset is released. That
  // edge is the one where the timer has already reached its last value.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HOLD: if (hold_cnt == HOLD_LAST) state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_HOLD;
    endcase
  end

  // Hold timer: counts the edges spent in ST_HOLD.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt <= '0;
    end else if (state_q == ST_HOLD && hold_cnt != HOLD_LAST) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end

  assign hold_active = (state_q == ST_HOLD);
  assign q_reset     = {NQ{hold_active}};

  // A queue is starving once it has been bypassed STARVE_MAX times in a
  // row. It is only considered while it still has data.
  always_comb begin
    for (int i = 0; i < NQ; i++) begin
      starving[i] = (starve_cnt[i] == CNT_MAX) && !q_empty[i];
    end
  end

  // Combinational arbiter. It is blocked entirely while the FIFOs are held
  // in reset, so q_read drops as soon as reset rises (asynchronously).
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    found       = 1'b0;
    if (!hold_active) begin
      if (lock) begin
        grant_valid = !q_empty[0];
      end else begin
        for (int i = 0; i < NQ; i++) begin
          if (!found && starving[i]) begin
            found     = 1'b1;
            grant_idx = SEL_W'(i);
          end
        end
        for (int i = 0; i < NQ; i++) begin
          if (!found && !q_empty[i]) begin
            found     = 1'b1;
            grant_idx = SEL_W'(i);
          end
        end
        grant_valid = found;
      end
    end
  end

  // Decode the grant into the one-hot strobe. sel is forced to 0 when idle.
  always_comb begin
    q_read    = '0;
    sel       = grant_valid ? grant_idx : '0;
    sel_valid = grant_valid;
    if (grant_valid) q_read[grant_idx] = 1'b1;
  end

  // Starvation counters. A counter clears when its queue is served or
  // runs dry, and otherwise counts the cycles the queue was passed over.
  // Counters keep running while lock is high, so a queue that starved
  // under lock wins on the first free cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NQ; i++) starve_cnt[i] <= '0;
    end else if (hold_active) begin
      for (int i = 0; i < NQ; i++) starve_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NQ; i++) begin
        if (q_read[i] || q_empty[i]) begin
          starve_cnt[i] <= '0;
        end else if (starve_cnt[i] != CNT_MAX) begin
          starve_cnt[i] <= starve_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign mon_space = q_space[PAUSE_Q*SPACE_W +: SPACE_W];

  // Only the monitored queue's space matters. The other fields are
  // collected here so it is clear that ignoring them is deliberate.
  assign unused_space = ^q_space;

  // Back-pressure with hysteresis. The flag sets below PAUSE_ON, clears at
  // or above PAUSE_OFF, and holds in between. It is held high while the
  // FIFOs are still in reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_pause <= 1'b1;
    end else if (hold_active) begin
      tx_pause <= 1'b1;
    end else if ({1'b0, mon_space} < ON_THR) begin
      tx_pause <= 1'b1;
    end else if ({1'b0, mon_space} >= OFF_THR) begin
      tx_pause <= 1'b0;
    end
  end

endmodule
